mem_port_master: RTL

Requester-side sequencer for the single-port data memory used by the matrix-multiply core. Accepts byte-read, 16-bit-read and 16-bit-write requests from the core's control logic over a valid/ready handshake. Converts them into the memory's port protocol: paired-byte write, registered 1-cycle read, and no read while writing. Returns read results over a one-cycle response pulse. Wide accesses are assembled little-endian: low byte at `addr`, high byte at `addr+1`.

---
 rtl/mem_port_master.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_master.sv
// Requester-side sequencer for the single-port data memory: turns byte/16-bit
// read and 16-bit write requests into the memory's paired-byte write / registered read protocol.
module mem_port_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_wide,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    mem_we,
    output logic [2*DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [ADDR_WIDTH-1:0]   mem_r_addr,
    input  logic [DATA_WIDTH-1:0]   mem_r_data
);

    localparam int unsigned WORD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_ADDR2,
        ST_RD_CAP,
        ST_RESP
    } state_e;

    state_e                  state_q;
    logic                    wide_q;
    logic                    rsp_valid_q;
    logic [WORD_WIDTH-1:0]   rsp_data_q;
    logic [WORD_WIDTH-1:0]   mem_w_data_q;
    logic [ADDR_WIDTH-1:0]   mem_w_addr_q;
    logic [ADDR_WIDTH-1:0]   mem_r_addr_q;
    logic                    accept_c;

    // Ready is held low during reset so a request can never be taken then.
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept_c  = req_valid && req_ready;

    // Write strobe is gated by reset so a WRITE cycle interrupted by reset never reaches memory.
    assign mem_we     = (state_q == ST_WRITE) && !reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign mem_w_data = mem_w_data_q;
    assign mem_w_addr = mem_w_addr_q;
    assign mem_r_addr = mem_r_addr_q;

    // Sequencer; the memory address registers load at accept so no req_* path reaches mem_*.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wide_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            mem_w_data_q <= '0;
            mem_w_addr_q <= '0;
            mem_r_addr_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (req_we) begin
                            mem_w_addr_q <= req_addr;
                            mem_w_data_q <= req_wdata;
                            state_q      <= ST_WRITE;
                        end else begin
                            mem_r_addr_q <= req_addr;
                            wide_q       <= req_wide;
                            state_q      <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    if (wide_q) begin
                        mem_r_addr_q <= mem_r_addr_q + ADDR_WIDTH'(1);
                        state_q      <= ST_RD_ADDR2;
                    end else begin
                        state_q <= ST_RD_CAP;
                    end
                end
                ST_RD_ADDR2: begin
                    rsp_data_q[DATA_WIDTH-1:0] <= mem_r_data;
                    state_q                    <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    if (wide_q) begin
                        rsp_data_q[WORD_WIDTH-1:DATA_WIDTH] <= mem_r_data;
                    end else begin
                        rsp_data_q <= {{DATA_WIDTH{1'b0}}, mem_r_data};
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
